tour_cmd_seq: RTL and testbench

Sequencer directly downstream of the tour solver. On `start_tour` (the solver's one-cycle `done` pulse) it walks the 24 stored solution moves by driving `mv_indx` and reading back the one-hot `move`. It splits each knight move into a vertical leg then a horizontal leg, and issues each leg as a 16-bit command to the motion controller under a ready/clear/response handshake. When no tour is running it passes host (UART) commands straight through to the controller.

---
 rtl/tour_pkg.sv | 47 ++++
 rtl/move_decode.sv | 20 ++
 rtl/tour_cmd_seq.sv | 110 +++++++++++
 tb/tb_tour_cmd_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared types, opcodes, headings and knight-move decode for the tour sequencer
package tour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_VWAIT,
        ST_HORZ,
        ST_HWAIT
    } tour_seq_state_t;

    localparam logic [3:0] CMD_MOVE     = 4'h2;
    localparam logic [3:0] CMD_MOVE_FAN = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    // sign bit set means the offset is negative (west / south)
    typedef struct packed {
        logic       dx_sign;
        logic [1:0] dx_mag;
        logic       dy_sign;
        logic [1:0] dy_mag;
        logic       valid;
    } move_fields_t;

    function automatic move_fields_t decode_move(input logic [7:0] move);
        move_fields_t f;
        f       = '0;
        f.valid = 1'b1;
        case (move)
            8'h01: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b0, 2'd1, 1'b0, 2'd2};
            8'h02: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b1, 2'd1, 1'b0, 2'd2};
            8'h04: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b1, 2'd2, 1'b0, 2'd1};
            8'h08: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b1, 2'd2, 1'b1, 2'd1};
            8'h10: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b1, 2'd1, 1'b1, 2'd2};
            8'h20: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b0, 2'd1, 1'b1, 2'd2};
            8'h40: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b0, 2'd2, 1'b1, 2'd1};
            8'h80: {f.dx_sign, f.dx_mag, f.dy_sign, f.dy_mag} = {1'b0, 2'd2, 1'b0, 2'd1};
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/move_decode.sv
// rtl/move_decode.sv - one-hot knight move to vertical and horizontal leg commands
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        valid
);

    move_fields_t f;

    always_comb begin
        f        = decode_move(move);
        valid    = f.valid;
        vert_cmd = {CMD_MOVE,     f.dy_sign ? HDG_S : HDG_N, 2'b00, f.dy_mag};
        horz_cmd = {CMD_MOVE_FAN, f.dx_sign ? HDG_W : HDG_E, 2'b00, f.dx_mag};
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - replays solved knight tour as leg commands, host pass-through when idle
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] host_cmd,
    input  logic        host_cmd_rdy,
    output logic        host_clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        resp_rdy,
    output logic        tour_busy,
    output logic        tour_done,
    output logic        move_err
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    tour_seq_state_t state;
    logic [4:0]      idx;
    logic [7:0]      hold;
    logic [15:0]     vert_cmd;
    logic [15:0]     horz_cmd;
    logic            hold_valid;
    logic            advance;

    move_decode u_move_decode (
        .move     (hold),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .valid    (hold_valid)
    );

    // The solver reads combinationally, so the next index is presented during the
    // accepting cycle and the following move is latched on the same edge.
    assign advance = (state == ST_HWAIT) && resp_rdy && (idx != LAST_IDX);
    assign mv_indx = (state == ST_IDLE) ? 5'd0 : (advance ? idx + 5'd1 : idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 5'd0;
            hold      <= 8'h00;
            tour_done <= 1'b0;
            move_err  <= 1'b0;
        end else begin
            tour_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_tour) begin
                        idx      <= 5'd0;
                        hold     <= move;
                        move_err <= 1'b0;
                        state    <= ST_VERT;
                    end
                end
                ST_VERT: begin
                    if (!hold_valid) begin
                        move_err <= 1'b1;
                        idx      <= 5'd0;
                        state    <= ST_IDLE;
                    end else if (clr_cmd_rdy) begin
                        state <= ST_VWAIT;
                    end
                end
                ST_VWAIT: begin
                    if (resp_rdy) state <= ST_HORZ;
                end
                ST_HORZ: begin
                    if (clr_cmd_rdy) state <= ST_HWAIT;
                end
                ST_HWAIT: begin
                    if (resp_rdy) begin
                        if (idx == LAST_IDX) begin
                            tour_done <= 1'b1;
                            idx       <= 5'd0;
                            state     <= ST_IDLE;
                        end else begin
                            idx   <= idx + 5'd1;
                            hold  <= move;
                            state <= ST_VERT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tour_busy = (state != ST_IDLE);

    always_comb begin
        cmd              = host_cmd;
        cmd_rdy          = host_cmd_rdy;
        host_clr_cmd_rdy = clr_cmd_rdy;
        if (!rst && state != ST_IDLE) begin
            host_clr_cmd_rdy = 1'b0;
            cmd              = (state == ST_HORZ || state == ST_HWAIT) ? horz_cmd : vert_cmd;
            cmd_rdy          = (state == ST_VERT && hold_valid) || (state == ST_HORZ);
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - directed table-driven bench for tour_cmd_seq
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] host_cmd = 16'h0000;
    logic        host_cmd_rdy = 1'b0;
    logic        host_clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        resp_rdy = 1'b0;
    logic        tour_busy;
    logic        tour_done;
    logic        move_err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int leak_cnt = 0;
    int max_idx = 0;

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] v;
        logic [15:0] h;
    } vec_t;

    vec_t       vec [8];
    logic [7:0] moves [24];

    always #5 clk = ~clk;

    tour_cmd_seq #(.NUM_MOVES(24)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .host_cmd         (host_cmd),
        .host_cmd_rdy     (host_cmd_rdy),
        .host_clr_cmd_rdy (host_clr_cmd_rdy),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .resp_rdy         (resp_rdy),
        .tour_busy        (tour_busy),
        .tour_done        (tour_done),
        .move_err         (move_err)
    );

    // solver model: combinational read of the stored tour
    always_comb move = (mv_indx < 5'd24) ? moves[mv_indx] : 8'h00;

    always @(posedge clk) begin
        if (tour_done === 1'b1) done_cnt++;
        if (int'(mv_indx) > max_idx) max_idx = int'(mv_indx);
    end

    always @(negedge clk) begin
        if (tour_busy === 1'b1 && host_clr_cmd_rdy !== 1'b0) leak_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_rdy"}, 32'(cmd_rdy), 32'd1);
    endtask

    task automatic do_leg(input string name, input logic [15:0] exp_cmd);
        wait_rdy(name);
        chk({name, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk({name, "_rdy_clr"}, 32'(cmd_rdy), 32'd0);
        tick();
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
    endtask

    task automatic start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    initial begin
        vec[0] = '{8'h01, 16'h2002, 16'h3BF1};
        vec[1] = '{8'h02, 16'h2002, 16'h33F1};
        vec[2] = '{8'h04, 16'h2001, 16'h33F2};
        vec[3] = '{8'h08, 16'h27F1, 16'h33F2};
        vec[4] = '{8'h10, 16'h27F2, 16'h33F1};
        vec[5] = '{8'h20, 16'h27F2, 16'h3BF1};
        vec[6] = '{8'h40, 16'h27F1, 16'h3BF2};
        vec[7] = '{8'h80, 16'h2001, 16'h3BF2};
        for (int i = 0; i < 24; i++) moves[i] = vec[(i + 3) % 8].mv;

        // reset and host pass-through
        host_cmd = 16'h4000;
        host_cmd_rdy = 1'b1;
        clr_cmd_rdy = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(tour_busy), 32'd0);
        chk("rst_idx", 32'(mv_indx), 32'd0);
        chk("rst_done", 32'(tour_done), 32'd0);
        chk("rst_err", 32'(move_err), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'h4000);
        rst = 1'b0;
        tick();
        chk("host_cmd", 32'(cmd), 32'h4000);
        chk("host_rdy", 32'(cmd_rdy), 32'd1);
        chk("host_clr", 32'(host_clr_cmd_rdy), 32'd1);
        chk("host_busy", 32'(tour_busy), 32'd0);
        clr_cmd_rdy = 1'b0;

        // full replay with host inputs asserted throughout
        host_cmd = 16'hFFFF;
        start();
        chk("a_busy_n1", 32'(tour_busy), 32'd1);
        chk("a_rdy_n1", 32'(cmd_rdy), 32'd1);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("a_idx%0d", i), 32'(mv_indx), 32'(i));
            do_leg($sformatf("a_v%0d", i), vec[(i + 3) % 8].v);
            do_leg($sformatf("a_h%0d", i), vec[(i + 3) % 8].h);
        end
        chk("a_done_pulse", 32'(tour_done), 32'd1);
        chk("a_busy_fall", 32'(tour_busy), 32'd0);
        chk("a_pass_cmd", 32'(cmd), 32'hFFFF);
        tick();
        chk("a_done_low", 32'(tour_done), 32'd0);
        chk("a_done_cnt", 32'(done_cnt), 32'd1);
        chk("a_max_idx", 32'(max_idx), 32'd23);
        chk("a_host_leak", 32'(leak_cnt), 32'd0);
        host_cmd_rdy = 1'b0;

        // non-one-hot move at index 5
        moves[5] = 8'h03;
        start();
        for (int i = 0; i < 5; i++) begin
            do_leg($sformatf("b_v%0d", i), vec[(i + 3) % 8].v);
            do_leg($sformatf("b_h%0d", i), vec[(i + 3) % 8].h);
        end
        chk("b_bad_rdy", 32'(cmd_rdy), 32'd0);
        tick();
        chk("b_err", 32'(move_err), 32'd1);
        chk("b_busy", 32'(tour_busy), 32'd0);
        chk("b_idx", 32'(mv_indx), 32'd0);
        chk("b_rdy", 32'(cmd_rdy), 32'd0);
        tick();
        chk("b_err_sticky", 32'(move_err), 32'd1);
        chk("b_done_cnt", 32'(done_cnt), 32'd1);
        moves[5] = vec[0].mv;

        // coincident resp/clear, start while busy, rst in HWAIT at index 10
        start();
        chk("c_err_clr", 32'(move_err), 32'd0);
        wait_rdy("c_v0");
        chk("c_v0_cmd", 32'(cmd), 32'(vec[3].v));
        clr_cmd_rdy = 1'b1;
        resp_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        resp_rdy = 1'b0;
        chk("c_vwait_rdy", 32'(cmd_rdy), 32'd0);
        start();
        tick();
        chk("c_ign_rdy", 32'(cmd_rdy), 32'd0);
        chk("c_ign_busy", 32'(tour_busy), 32'd1);
        chk("c_ign_idx", 32'(mv_indx), 32'd0);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        chk("c_h0_rise", 32'(cmd_rdy), 32'd1);
        do_leg("c_h0", vec[3].h);
        for (int i = 1; i < 10; i++) begin
            do_leg($sformatf("c_v%0d", i), vec[(i + 3) % 8].v);
            do_leg($sformatf("c_h%0d", i), vec[(i + 3) % 8].h);
        end
        do_leg("c_v10", vec[(10 + 3) % 8].v);
        wait_rdy("c_h10");
        chk("c_h10_cmd", 32'(cmd), 32'(vec[(10 + 3) % 8].h));
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk("c_hwait_idx", 32'(mv_indx), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c_rst_busy", 32'(tour_busy), 32'd0);
        chk("c_rst_idx", 32'(mv_indx), 32'd0);
        chk("c_rst_done", 32'(tour_done), 32'd0);
        chk("c_rst_rdy", 32'(cmd_rdy), 32'd0);
        tick();
        chk("c_done_cnt", 32'(done_cnt), 32'd1);

        // restart after abort begins at index 0
        start();
        chk("d_idx", 32'(mv_indx), 32'd0);
        chk("d_rdy", 32'(cmd_rdy), 32'd1);
        chk("d_cmd", 32'(cmd), 32'(vec[3].v));
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
